rv32_test_monitor: RTL and testbench

- Synthesizable end-of-test monitor for rv32 cores, instantiated in benches and FPGA builds alongside one or more cores.
- Snoops each channel's data-memory write bus for a store to the "tohost" address and decodes pass/fail.
- Counts cycles and runs a timeout watchdog.
- Presents sticky done/pass/timeout status, which bench code uses to end simulation.

---
 rtl/rv32_test_monitor.sv | 129 ++++++++++++
 tb/tb_rv32_test_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_test_monitor.sv
// End-of-test monitor: snoops tohost stores, cycle counter and watchdog.
// Per-channel retire counters are built only with RV32_TEST_MONITOR_INSTRET_EN.
module rv32_test_monitor #(
    parameter int                NUM_CH         = 1,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'd7777,
    parameter int                CNT_W          = 32,
    parameter int                TIMEOUT_CYCLES = 100000,
    localparam int               FC_W           = $clog2(NUM_CH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mon_clr,
    input  logic [NUM_CH-1:0]       mem_we,
    input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    input  logic [NUM_CH-1:0]       retire,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [NUM_CH-1:0]       done_mask,
    output logic [FC_W-1:0]         fail_ch,
    output logic [DATA_W-1:0]       fail_code,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [NUM_CH*CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PASS_DONE = 2'd1,
        FAIL_DONE = 2'd2,
        TO_DONE   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] rep, mask_nxt;
    logic [FC_W-1:0]   fch_nxt, fail_idx;
    logic [DATA_W-1:0] fcode_nxt, fail_dat;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              fail_any, upd;

    // After a fail, stragglers still mark themselves reported.
    assign upd = (state == RUN) || (state == FAIL_DONE);

    always_comb begin
        rep      = '0;
        fail_any = 1'b0;
        fail_idx = '0;
        fail_dat = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            rep[i] = upd && mem_we[i] && !done_mask[i] &&
                     (mem_addr[i*ADDR_W +: ADDR_W] == TOHOST_ADDR);
            if (rep[i] && (mem_wdata[i*DATA_W +: DATA_W] != DATA_W'(1))) begin
                fail_any = 1'b1;
                fail_idx = FC_W'(i);
                fail_dat = mem_wdata[i*DATA_W +: DATA_W] >> 1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = done_mask | rep;
        fch_nxt   = fail_ch;
        fcode_nxt = fail_code;
        cnt_nxt   = cycle_cnt;
        if (state == RUN) begin
            if (cycle_cnt != '1)
                cnt_nxt = cycle_cnt + 1'b1;
            if (fail_any) begin
                fch_nxt   = fail_idx;
                fcode_nxt = fail_dat;
                state_nxt = FAIL_DONE;
            end else if (&mask_nxt) begin
                state_nxt = PASS_DONE;
            end else if ((TIMEOUT_CYCLES != 0) &&
                         (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                state_nxt = TO_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            done_mask <= '0;
            fail_ch   <= '1;
            fail_code <= '0;
            cycle_cnt <= '0;
        end else if (mon_clr) begin
            state     <= RUN;
            done_mask <= '0;
            fail_ch   <= '1;
            fail_code <= '0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_nxt;
            done_mask <= mask_nxt;
            fail_ch   <= fch_nxt;
            fail_code <= fcode_nxt;
            cycle_cnt <= cnt_nxt;
        end
    end

    assign done    = (state != RUN);
    assign pass    = (state == PASS_DONE);
    assign timeout = (state == TO_DONE);

`ifdef RV32_TEST_MONITOR_INSTRET_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ir
        logic [CNT_W-1:0] ir;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                ir <= '0;
            else if (mon_clr)
                ir <= '0;
            else if ((state == RUN) && retire[g] && (ir != '1))
                ir <= ir + 1'b1;
        end
        assign instret[g*CNT_W +: CNT_W] = ir;
    end
`else
    logic unused_retire;
    assign unused_retire = ^retire;
    assign instret       = '0;
`endif

endmodule

// File: tb/tb_rv32_test_monitor.sv
// Scoreboard bench for rv32_test_monitor across 1/2/4 channels
// and a short-watchdog build.
module tb_rv32_test_monitor;

    localparam logic [31:0] TH = 32'd7777;
`ifdef RV32_TEST_MONITOR_INSTRET_EN
    localparam logic [63:0] IR40 = 64'd40;
`else
    localparam logic [63:0] IR40 = 64'd0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic mon_clr;
    always #5 clk = ~clk;

    logic        a_we, a_ret, a_done, a_pass, a_to;
    logic [31:0] a_addr, a_wd, a_fcode, a_cnt, a_ir;
    logic [0:0]  a_mask, a_fch;

    logic [1:0]  b_we, b_ret, b_mask, b_fch;
    logic [63:0] b_addr, b_wd, b_ir;
    logic        b_done, b_pass, b_to;
    logic [31:0] b_fcode, b_cnt;

    logic [3:0]   c_we, c_ret, c_mask;
    logic [127:0] c_addr, c_wd, c_ir;
    logic [2:0]   c_fch;
    logic         c_done, c_pass, c_to;
    logic [31:0]  c_fcode, c_cnt;

    logic        t_we, t_ret, t_done, t_pass, t_to;
    logic [31:0] t_addr, t_wd, t_fcode, t_cnt, t_ir;
    logic [0:0]  t_mask, t_fch;

    rv32_test_monitor #(.NUM_CH(1)) u1 (
        .clk(clk), .reset_n(reset_n), .mon_clr(mon_clr),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wd),
        .retire(a_ret), .done(a_done), .pass(a_pass),
        .timeout(a_to), .done_mask(a_mask), .fail_ch(a_fch),
        .fail_code(a_fcode), .cycle_cnt(a_cnt), .instret(a_ir)
    );

    rv32_test_monitor #(.NUM_CH(2)) u2 (
        .clk(clk), .reset_n(reset_n), .mon_clr(mon_clr),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wd),
        .retire(b_ret), .done(b_done), .pass(b_pass),
        .timeout(b_to), .done_mask(b_mask), .fail_ch(b_fch),
        .fail_code(b_fcode), .cycle_cnt(b_cnt), .instret(b_ir)
    );

    rv32_test_monitor #(.NUM_CH(4)) u4 (
        .clk(clk), .reset_n(reset_n), .mon_clr(mon_clr),
        .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wd),
        .retire(c_ret), .done(c_done), .pass(c_pass),
        .timeout(c_to), .done_mask(c_mask), .fail_ch(c_fch),
        .fail_code(c_fcode), .cycle_cnt(c_cnt), .instret(c_ir)
    );

    rv32_test_monitor #(.NUM_CH(1), .TIMEOUT_CYCLES(100)) ut (
        .clk(clk), .reset_n(reset_n), .mon_clr(mon_clr),
        .mem_we(t_we), .mem_addr(t_addr), .mem_wdata(t_wd),
        .retire(t_ret), .done(t_done), .pass(t_pass),
        .timeout(t_to), .done_mask(t_mask), .fail_ch(t_fch),
        .fail_code(t_fcode), .cycle_cnt(t_cnt), .instret(t_ir)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        mon_clr = 1'b0;
        a_we = 0; a_ret = 0; a_addr = 0; a_wd = 0;
        b_we = 0; b_ret = 0; b_addr = 0; b_wd = 0;
        c_we = 0; c_ret = 0; c_addr = 0; c_wd = 0;
        t_we = 0; t_ret = 0; t_addr = 0; t_wd = 0;
        tick(2);

        // reset values
        sb_push("rst_done", 0);
        sb_push("rst_pass", 0);
        sb_push("rst_to", 0);
        sb_push("rst_mask", 0);
        sb_push("rst_fch", 64'h7);
        sb_push("rst_fcode", 0);
        sb_push("rst_cnt", 0);
        sb_push("rst_ir", 0);
        sb_pop(c_done); sb_pop(c_pass); sb_pop(c_to);
        sb_pop(c_mask); sb_pop(c_fch); sb_pop(c_fcode);
        sb_pop(c_cnt); sb_pop(c_ir);

        // single channel pass at cycle 50, retire for 40 cycles
        reset_n = 1'b1;
        a_ret = 1'b1;
        tick(40);
        a_ret = 1'b0;
        tick(10);
        sb_push("a_done_pre", 0);
        sb_pop(a_done);
        a_we = 1; a_addr = TH; a_wd = 32'd1;
        sb_push("a_done", 1);
        sb_push("a_pass", 1);
        sb_push("a_fch", 1);
        sb_push("a_cnt", 51);
        sb_push("a_ir", IR40);
        tick(1);
        sb_pop(a_done); sb_pop(a_pass); sb_pop(a_fch);
        sb_pop(a_cnt); sb_pop(a_ir);
        a_we = 0;
        a_ret = 1'b1;
        sb_push("a_cnt_frz", 51);
        sb_push("a_ir_frz", IR40);
        sb_push("a_done_stk", 1);
        tick(5);
        sb_pop(a_cnt); sb_pop(a_ir); sb_pop(a_done);
        a_ret = 1'b0;

        // asynchronous reset out of PASS_DONE
        reset_n = 1'b0;
        #1;
        sb_push("ar_done", 0);
        sb_push("ar_pass", 0);
        sb_push("ar_cnt", 0);
        sb_push("ar_fch", 1);
        sb_push("ar_ir", 0);
        sb_pop(a_done); sb_pop(a_pass); sb_pop(a_cnt);
        sb_pop(a_fch); sb_pop(a_ir);
        @(negedge clk);
        reset_n = 1'b1;

        // other-address store ignored
        tick(10);
        c_we = 4'b0001; c_addr[31:0] = TH - 1; c_wd[31:0] = 0;
        sb_push("c_other_done", 0);
        sb_push("c_other_mask", 0);
        tick(1);
        c_we = 0;
        sb_pop(c_done); sb_pop(c_mask);

        // cycle 20: b ch1 fails (7), c ch1+ch3 fail (5)
        tick(9);
        b_we = 2'b10; b_addr[63:32] = TH; b_wd[63:32] = 7;
        c_we = 4'b1010;
        c_addr[32 +: 32] = TH; c_addr[96 +: 32] = TH;
        c_wd[32 +: 32] = 5; c_wd[96 +: 32] = 5;
        sb_push("b_done", 1);
        sb_push("b_pass", 0);
        sb_push("b_fch", 1);
        sb_push("b_fcode", 3);
        sb_push("b_mask", 2'b10);
        sb_push("b_cnt", 21);
        sb_push("c_fch", 1);
        sb_push("c_fcode", 2);
        sb_push("c_mask", 4'b1010);
        sb_push("c_pass", 0);
        tick(1);
        b_we = 0; c_we = 0;
        sb_pop(b_done); sb_pop(b_pass); sb_pop(b_fch);
        sb_pop(b_fcode); sb_pop(b_mask); sb_pop(b_cnt);
        sb_pop(c_fch); sb_pop(c_fcode); sb_pop(c_mask);
        sb_pop(c_pass);

        // cycle 30: b ch0 passes late, c ch2/ch3 store 9
        tick(9);
        b_we = 2'b01; b_addr[31:0] = TH; b_wd[31:0] = 1;
        c_we = 4'b1100;
        c_addr[64 +: 32] = TH; c_wd[64 +: 32] = 9;
        c_wd[96 +: 32] = 9;
        sb_push("b_mask2", 2'b11);
        sb_push("b_pass2", 0);
        sb_push("b_fch2", 1);
        sb_push("b_fcode2", 3);
        sb_push("b_cnt2", 21);
        sb_push("c_mask2", 4'b1110);
        sb_push("c_fch2", 1);
        sb_push("c_fcode2", 2);
        tick(1);
        b_we = 0; c_we = 0;
        sb_pop(b_mask); sb_pop(b_pass); sb_pop(b_fch);
        sb_pop(b_fcode); sb_pop(b_cnt);
        sb_pop(c_mask); sb_pop(c_fch); sb_pop(c_fcode);

        // mon_clr beats a simultaneous pass store
        mon_clr = 1'b1;
        b_we = 2'b01;
        sb_push("clr_done", 0);
        sb_push("clr_pass", 0);
        sb_push("clr_mask", 0);
        sb_push("clr_fch", 3);
        sb_push("clr_fcode", 0);
        sb_push("clr_cnt", 0);
        tick(1);
        mon_clr = 1'b0;
        b_we = 0;
        sb_pop(b_done); sb_pop(b_pass); sb_pop(b_mask);
        sb_pop(b_fch); sb_pop(b_fcode); sb_pop(b_cnt);
        tick(4);
        b_we = 2'b11; b_addr = {TH, TH}; b_wd = {32'd1, 32'd1};
        sb_push("fresh_pass", 1);
        sb_push("fresh_done", 1);
        sb_push("fresh_fch", 3);
        sb_push("fresh_mask", 2'b11);
        sb_push("fresh_cnt", 5);
        tick(1);
        b_we = 0;
        sb_pop(b_pass); sb_pop(b_done); sb_pop(b_fch);
        sb_pop(b_mask); sb_pop(b_cnt);

        // watchdog expiry
        do_reset();
        tick(99);
        sb_push("to_pre_done", 0);
        sb_push("to_pre_to", 0);
        sb_push("to_pre_cnt", 99);
        sb_pop(t_done); sb_pop(t_to); sb_pop(t_cnt);
        sb_push("to_to", 1);
        sb_push("to_done", 1);
        sb_push("to_pass", 0);
        sb_push("to_cnt", 100);
        tick(1);
        sb_pop(t_to); sb_pop(t_done); sb_pop(t_pass); sb_pop(t_cnt);
        t_we = 1; t_addr = TH; t_wd = 1;
        sb_push("to_late_mask", 0);
        sb_push("to_late_pass", 0);
        sb_push("to_late_cnt", 100);
        sb_push("to_late_to", 1);
        tick(1);
        t_we = 0;
        sb_pop(t_mask); sb_pop(t_pass); sb_pop(t_cnt); sb_pop(t_to);

        // completion on the watchdog edge wins
        do_reset();
        tick(99);
        t_we = 1; t_addr = TH; t_wd = 1;
        sb_push("tie_pass", 1);
        sb_push("tie_to", 0);
        sb_push("tie_done", 1);
        sb_push("tie_cnt", 100);
        tick(1);
        t_we = 0;
        sb_pop(t_pass); sb_pop(t_to); sb_pop(t_done); sb_pop(t_cnt);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
